// File: rtl/mac_pkg.sv
// Shared types and default widths for the MAC sequencer slice.
package mac_pkg;

  localparam int DATA_W = 4;
  localparam int ADDR_W = 4;
  localparam int LEN_W  = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    CAPT = 2'd2,
    OUT  = 2'd3
  } state_t;

endpackage

// File: rtl/mac_addr_gen.sv
// Base/length registers and element index; produces buffer read addresses and last-element flag.
module mac_addr_gen
  import mac_pkg::*;
#(
  parameter int ADDR_W = mac_pkg::ADDR_W,
  parameter int LEN_W  = mac_pkg::LEN_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic [LEN_W-1:0]  len,
  input  logic [ADDR_W-1:0] if_base,
  input  logic [ADDR_W-1:0] wt_base,
  output logic [ADDR_W-1:0] if_addr,
  output logic [ADDR_W-1:0] wt_addr,
  output logic              last
);

  logic [LEN_W-1:0]  len_r;
  logic [LEN_W-1:0]  idx;
  logic [ADDR_W-1:0] if_base_r;
  logic [ADDR_W-1:0] wt_base_r;
  logic [ADDR_W-1:0] idx_a;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_r     <= '0;
      idx       <= '0;
      if_base_r <= '0;
      wt_base_r <= '0;
    end else if (load) begin
      len_r     <= len;
      idx       <= '0;
      if_base_r <= if_base;
      wt_base_r <= wt_base;
    end else if (step) begin
      idx <= idx + LEN_W'(1);
    end
  end

  // Addresses wrap naturally modulo the buffer depth.
  assign idx_a   = ADDR_W'(idx);
  assign if_addr = if_base_r + idx_a;
  assign wt_addr = wt_base_r + idx_a;
  assign last    = (idx == (len_r - LEN_W'(1)));

endmodule

// File: rtl/mac_seq_ctrl.sv
// Dot-product sequencer: issues buffer reads, aligns MAC controls to returned data, and hands off the result.
module mac_seq_ctrl
  import mac_pkg::*;
#(
  parameter int DATA_W = mac_pkg::DATA_W,
  parameter int ADDR_W = mac_pkg::ADDR_W,
  parameter int LEN_W  = mac_pkg::LEN_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic [ADDR_W-1:0] if_base,
  input  logic [ADDR_W-1:0] wt_base,
  input  logic              abort,
  output logic              busy,
  output logic              rd_en,
  output logic [ADDR_W-1:0] if_addr,
  output logic [ADDR_W-1:0] wt_addr,
  output logic              mac_en,
  output logic              mac_lastdata,
  output logic              mac_clr,
  input  logic [DATA_W-1:0] mac_acc,
  output logic [DATA_W-1:0] res_data,
  output logic              res_valid,
  input  logic              res_ready
);

  state_t state, state_n;

  logic              load;
  logic              step;
  logic              last;
  logic              flush;
  logic              run_last_p0;
  logic              vld_p1;
  logic              last_p1;
  logic              clr_p1;
  logic [ADDR_W-1:0] if_addr_g;
  logic [ADDR_W-1:0] wt_addr_g;
  logic [DATA_W-1:0] res_q;
  logic              res_vld;

  mac_addr_gen #(
    .ADDR_W(ADDR_W),
    .LEN_W (LEN_W)
  ) u_addr_gen (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .step   (step),
    .len    (len),
    .if_base(if_base),
    .wt_base(wt_base),
    .if_addr(if_addr_g),
    .wt_addr(wt_addr_g),
    .last   (last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n     = state;
    load        = 1'b0;
    step        = 1'b0;
    flush       = 1'b0;
    run_last_p0 = 1'b0;
    case (state)
      IDLE: begin
        if (start && (len != '0)) begin
          load    = 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        step        = 1'b1;
        run_last_p0 = last;
        if (abort) begin
          flush   = 1'b1;
          state_n = IDLE;
        end else if (last) begin
          state_n = CAPT;
        end
      end
      CAPT: begin
        if (abort) begin
          flush   = 1'b1;
          state_n = IDLE;
        end else begin
          state_n = OUT;
        end
      end
      OUT: begin
        // abort takes priority over a same-cycle handshake: the result is dropped.
        if (abort || (res_vld && res_ready)) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy    = (state != IDLE);
  assign rd_en   = (state == RUN);
  assign if_addr = rd_en ? if_addr_g : '0;
  assign wt_addr = rd_en ? wt_addr_g : '0;

  // p0 -> p1: controls delayed one cycle to meet the buffer read data at the MAC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      clr_p1  <= 1'b0;
    end else begin
      vld_p1  <= rd_en && !flush;
      last_p1 <= run_last_p0 && !flush;
      clr_p1  <= flush;
    end
  end

  assign mac_en       = vld_p1;
  assign mac_lastdata = last_p1;
  assign mac_clr      = clr_p1;

  // Result stage: the MAC's registered sum is stable on the first OUT cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_q   <= '0;
      res_vld <= 1'b0;
    end else if (state == OUT) begin
      if (abort) begin
        res_vld <= 1'b0;
      end else if (!res_vld) begin
        res_q   <= mac_acc;
        res_vld <= 1'b1;
      end else if (res_ready) begin
        res_vld <= 1'b0;
      end
    end
  end

  assign res_data  = res_q;
  assign res_valid = res_vld;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Randomized self-checking bench for mac_seq_ctrl with buffer and MAC behavioural models.
module tb_mac_seq_ctrl;

  localparam int MAXC = 60;

  logic       clk;
  logic       reset;
  logic       start;
  logic [4:0] len;
  logic [3:0] if_base;
  logic [3:0] wt_base;
  logic       abort;
  logic       busy;
  logic       rd_en;
  logic [3:0] if_addr;
  logic [3:0] wt_addr;
  logic       mac_en;
  logic       mac_lastdata;
  logic       mac_clr;
  logic [3:0] mac_acc;
  logic [3:0] res_data;
  logic       res_valid;
  logic       res_ready;

  int checks = 0;
  int errors = 0;

  mac_seq_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .len         (len),
    .if_base     (if_base),
    .wt_base     (wt_base),
    .abort       (abort),
    .busy        (busy),
    .rd_en       (rd_en),
    .if_addr     (if_addr),
    .wt_addr     (wt_addr),
    .mac_en      (mac_en),
    .mac_lastdata(mac_lastdata),
    .mac_clr     (mac_clr),
    .mac_acc     (mac_acc),
    .res_data    (res_data),
    .res_valid   (res_valid),
    .res_ready   (res_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Buffers with 1-cycle synchronous read, and a 4-bit MAC that registers its sum on lastdata.
  logic [3:0] ifm [16];
  logic [3:0] wtm [16];
  logic [3:0] if_q, wt_q, sum;

  always @(posedge clk) begin
    if (rd_en) begin
      if_q <= ifm[if_addr];
      wt_q <= wtm[wt_addr];
    end
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      sum     <= 4'd0;
      mac_acc <= 4'd0;
    end else if (mac_clr) begin
      sum     <= 4'd0;
      mac_acc <= 4'd0;
    end else if (mac_en) begin
      if (mac_lastdata) begin
        mac_acc <= 4'(sum + if_q * wt_q);
        sum     <= 4'd0;
      end else begin
        sum <= 4'(sum + if_q * wt_q);
      end
    end
  end

  function automatic logic [3:0] ref_dot(input int n, input logic [3:0] ib, input logic [3:0] wb);
    int s = 0;
    for (int i = 0; i < n; i++)
      s += int'(ifm[(int'(ib) + i) % 16]) * int'(wtm[(int'(wb) + i) % 16]);
    return 4'(s % 16);
  endfunction

  // Per-cycle trace of one operation; cycle 1 is the first cycle after the start edge.
  logic       tr_rd [MAXC], tr_en [MAXC], tr_last [MAXC], tr_clr [MAXC], tr_vld [MAXC], tr_busy [MAXC];
  logic [3:0] tr_if [MAXC], tr_wt [MAXC], tr_res [MAXC];
  int         done_c, first_v;
  logic [3:0] first_res;

  task automatic run_op(input int n, input logic [3:0] ib, input logic [3:0] wb,
                        input int hold, input int abort_c, input int spulse_c);
    int vcnt = 0;
    done_c = -1; first_v = -1; first_res = 4'd0;
    for (int c = 0; c < MAXC; c++) begin
      tr_rd[c] = 0; tr_en[c] = 0; tr_last[c] = 0; tr_clr[c] = 0; tr_vld[c] = 0; tr_busy[c] = 0;
      tr_if[c] = 0; tr_wt[c] = 0; tr_res[c] = 0;
    end
    @(negedge clk);
    start = 1'b1; len = 5'(n); if_base = ib; wt_base = wb; abort = 1'b0; res_ready = 1'b0;
    @(posedge clk);
    for (int c = 1; c < MAXC; c++) begin
      @(negedge clk);
      start = (c == spulse_c);
      abort = (c == abort_c);
      tr_rd[c] = rd_en; tr_en[c] = mac_en; tr_last[c] = mac_lastdata; tr_clr[c] = mac_clr;
      tr_vld[c] = res_valid; tr_busy[c] = busy; tr_if[c] = if_addr; tr_wt[c] = wt_addr; tr_res[c] = res_data;
      if (res_valid) begin
        vcnt++;
        if (first_v < 0) begin first_v = c; first_res = res_data; end
      end
      res_ready = res_valid && (vcnt > hold);
      if (done_c < 0 && !busy) done_c = c;
      if (done_c >= 0 && c >= done_c + 2) break;
    end
    start = 1'b0; abort = 1'b0; res_ready = 1'b0;
    checks++;
    if (done_c < 0) begin
      errors++;
      $display("FAIL op_timeout: busy still high after %0d cycles, required to return to idle", MAXC);
      done_c = MAXC - 3;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; len = '0; if_base = '0; wt_base = '0; abort = 1'b0; res_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, rd_en, mac_en, mac_lastdata, mac_clr, res_valid} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b, required 000000", {busy, rd_en, mac_en, mac_lastdata, mac_clr, res_valid});
    end
    checks++;
    if ({if_addr, wt_addr, res_data} !== 12'h000) begin
      errors++;
      $display("FAIL reset_data: got %h, required 000", {if_addr, wt_addr, res_data});
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_len3();
    int bad = 0;
    ifm[0] = 1; ifm[1] = 2; ifm[2] = 3; wtm[8] = 2; wtm[9] = 2; wtm[10] = 2;
    run_op(3, 4'h0, 4'h8, 0, -1, -1);
    for (int c = 1; c < done_c + 2; c++)
      if (tr_en[c] !== (c >= 2 && c <= 4) || tr_last[c] !== (c == 4)) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL len3_align: %0d bad cycles for mac_en/lastdata, required 0", bad); end
    checks++;
    if (first_v != 6 || first_res !== ref_dot(3, 4'h0, 4'h8)) begin
      errors++; $display("FAIL len3_result: valid at %0d data %h, required cycle 6 data %h", first_v, first_res, ref_dot(3, 4'h0, 4'h8));
    end
    checks++;
    if (done_c != 7) begin errors++; $display("FAIL len3_idle: busy low at %0d, required 7", done_c); end
  endtask

  task automatic test_len1();
    ifm[3] = 3; wtm[5] = 5;
    run_op(1, 4'h3, 4'h5, 0, -1, -1);
    checks++;
    if (tr_en[2] !== 1'b1 || tr_last[2] !== 1'b1 || tr_en[1] !== 1'b0 || tr_en[3] !== 1'b0 || tr_last[3] !== 1'b0) begin
      errors++; $display("FAIL len1_align: en c1..3=%b%b%b last c2..3=%b%b, required 010 10", tr_en[1], tr_en[2], tr_en[3], tr_last[2], tr_last[3]);
    end
    checks++;
    if (first_v != 4 || first_res !== 4'hF) begin
      errors++; $display("FAIL len1_result: valid at %0d data %h, required cycle 4 data f", first_v, first_res);
    end
  endtask

  task automatic test_overflow();
    ifm[6] = 4; ifm[7] = 4; wtm[12] = 4; wtm[13] = 4;
    run_op(2, 4'h6, 4'hC, 0, -1, -1);
    checks++;
    if (first_res !== 4'h0 || first_v != 5) begin
      errors++; $display("FAIL overflow: valid at %0d data %h, required cycle 5 data 0", first_v, first_res);
    end
  endtask

  task automatic test_wrap();
    logic [3:0] exp_if [4];
    int bad = 0;
    exp_if[0] = 4'hE; exp_if[1] = 4'hF; exp_if[2] = 4'h0; exp_if[3] = 4'h1;
    for (int i = 0; i < 16; i++) begin ifm[i] = 4'($urandom); wtm[i] = 4'($urandom); end
    run_op(4, 4'hE, 4'h3, 0, -1, -1);
    for (int c = 1; c <= 4; c++)
      if (tr_if[c] !== exp_if[c-1] || tr_rd[c] !== 1'b1) bad++;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL wrap_addr: got %h %h %h %h, required e f 0 1", tr_if[1], tr_if[2], tr_if[3], tr_if[4]);
    end
    checks++;
    if (first_res !== ref_dot(4, 4'hE, 4'h3)) begin
      errors++; $display("FAIL wrap_result: got %h, required %h", first_res, ref_dot(4, 4'hE, 4'h3));
    end
  endtask

  task automatic test_backpressure();
    int bad = 0;
    ifm[0] = 1; ifm[1] = 2; ifm[2] = 3; wtm[8] = 2; wtm[9] = 2; wtm[10] = 2;
    run_op(3, 4'h0, 4'h8, 5, -1, 8);
    for (int c = 6; c <= 11; c++)
      if (tr_vld[c] !== 1'b1 || tr_res[c] !== 4'hC || tr_busy[c] !== 1'b1) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL bp_hold: %0d cycles lost valid/data/busy, required 0", bad); end
    checks++;
    if (done_c != 12) begin errors++; $display("FAIL bp_accept: busy low at %0d, required 12", done_c); end
    checks++;
    if (tr_busy[13] !== 1'b0 || tr_rd[13] !== 1'b0 || tr_busy[14] !== 1'b0) begin
      errors++; $display("FAIL bp_start_ignored: busy after accept %b%b, required 00", tr_busy[13], tr_busy[14]);
    end
  endtask

  task automatic test_abort();
    int nclr = 0, nvld = 0;
    for (int i = 0; i < 16; i++) begin ifm[i] = 4'($urandom_range(1, 15)); wtm[i] = 4'($urandom_range(1, 15)); end
    run_op(8, 4'h0, 4'h0, 0, 3, -1);
    for (int c = 1; c < done_c + 3 && c < MAXC; c++) begin
      if (tr_clr[c]) nclr++;
      if (tr_vld[c]) nvld++;
    end
    checks++;
    if (nclr != 1 || tr_clr[4] !== 1'b1) begin
      errors++; $display("FAIL abort_clr: %0d clr cycles, clr at 4 = %b, required 1 and 1", nclr, tr_clr[4]);
    end
    checks++;
    if (nvld != 0 || done_c != 4) begin
      errors++; $display("FAIL abort_idle: %0d valid cycles, idle at %0d, required 0 and 4", nvld, done_c);
    end
    checks++;
    if (tr_en[4] !== 1'b0 || tr_last[4] !== 1'b0) begin
      errors++; $display("FAIL abort_squash: en/last at 4 = %b%b, required 00", tr_en[4], tr_last[4]);
    end
    ifm[9] = 1; ifm[10] = 1; wtm[2] = 3; wtm[3] = 3;
    run_op(2, 4'h9, 4'h2, 0, -1, -1);
    checks++;
    if (first_res !== 4'h6) begin errors++; $display("FAIL abort_next: got %h, required 6", first_res); end
  endtask

  task automatic test_len0();
    int bad = 0;
    @(negedge clk);
    start = 1'b1; len = 5'd0;
    repeat (3) begin
      @(negedge clk);
      if (busy !== 1'b0 || rd_en !== 1'b0) bad++;
    end
    start = 1'b0;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL len0_ignored: %0d cycles busy, required 0", bad); end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    start = 1'b1; len = 5'd8; if_base = 4'h2; wt_base = 4'h4;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({busy, rd_en, mac_en, mac_lastdata, mac_clr, res_valid, if_addr, wt_addr, res_data} !== 18'h0) begin
      errors++;
      $display("FAIL async_reset: outputs %h, required 0", {busy, rd_en, mac_en, mac_lastdata, mac_clr, res_valid, if_addr, wt_addr, res_data});
    end
    @(negedge clk); reset = 1'b0;
    ifm[5] = 7; ifm[6] = 3; wtm[1] = 2; wtm[2] = 9;
    run_op(2, 4'h5, 4'h1, 0, -1, -1);
    checks++;
    if (first_res !== ref_dot(2, 4'h5, 4'h1) || first_v != 5) begin
      errors++; $display("FAIL async_reset_next: valid at %0d data %h, required cycle 5 data %h", first_v, first_res, ref_dot(2, 4'h5, 4'h1));
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 8; k++) begin
      int n, h, bad_a, bad_t;
      logic [3:0] ib, wb, exp;
      n = $urandom_range(1, 31); h = $urandom_range(0, 3);
      ib = 4'($urandom); wb = 4'($urandom);
      for (int i = 0; i < 16; i++) begin ifm[i] = 4'($urandom); wtm[i] = 4'($urandom); end
      exp = ref_dot(n, ib, wb);
      run_op(n, ib, wb, h, -1, -1);
      bad_a = 0; bad_t = 0;
      for (int c = 1; c <= n; c++)
        if (tr_rd[c] !== 1'b1 || tr_if[c] !== 4'(int'(ib) + c - 1) || tr_wt[c] !== 4'(int'(wb) + c - 1)) bad_a++;
      for (int c = 1; c < done_c + 2 && c < MAXC; c++)
        if (tr_en[c] !== (c >= 2 && c <= n + 1) || tr_last[c] !== (c == n + 1)) bad_t++;
      checks++;
      if (bad_a != 0) begin errors++; $display("FAIL rand_addr[%0d]: %0d bad read cycles (len %0d), required 0", k, bad_a, n); end
      checks++;
      if (bad_t != 0) begin errors++; $display("FAIL rand_align[%0d]: %0d bad en/last cycles (len %0d), required 0", k, bad_t, n); end
      checks++;
      if (first_res !== exp || first_v != n + 3) begin
        errors++; $display("FAIL rand_result[%0d]: valid at %0d data %h, required cycle %0d data %h", k, first_v, first_res, n + 3, exp);
      end
      checks++;
      if (done_c != n + 4 + h) begin errors++; $display("FAIL rand_done[%0d]: idle at %0d, required %0d", k, done_c, n + 4 + h); end
    end
  endtask

  initial begin
    test_reset();
    test_len3();
    test_len1();
    test_overflow();
    test_wrap();
    test_backpressure();
    test_abort();
    test_len0();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
